mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller that owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and sequences a fixed-latency busy window.
- Returns mfhi/mflo data to the E stage.
- Raises a stall request to the hazard unit so that any HI/LO instruction in D is held in REGD while the unit is busy.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
valid_e  in  1  E-stage instruction is real (not a bubble or cleared slot)
hilo_op_e  in  4  HILOOp of the E-stage instruction
v1_e  in  32  forwarded rs value (dividend, multiplicand, mthi/mtlo source)
v2_e  in  32  forwarded rt value (divisor, multiplier)
hilo_op_d  in  4  HILOOp of the D-stage instruction
hi  out  32  HI register
lo  out  32  LO register
hilo_e  out  32  mfhi gives hi, mflo gives lo, otherwise 0 (combinational)
busy  out  1  operation in progress
stall_req  out  1  stall D/F and clear E

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- HILOOp encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9..15 are treated as NONE.
- Reset values: hi=0, lo=0, busy=0, state IDLE, counter 0, pending result 0.
- Reset mid-operation discards the pending result and returns the unit to IDLE.
- start = valid_e & (hilo_op_e in 1..4) & state==IDLE.
- States:
  - IDLE to RUN on start. At that edge: counter loads MULT_CYCLES or DIV_CYCLES; pending {hi,lo} is computed from v1_e/v2_e and registered.
  - RUN: counter decrements each cycle.
  - RUN with counter==1: at that edge, pending is committed to hi/lo and the state returns to IDLE.
- Latency: start sampled in cycle t. busy is 1 in cycles t+1..t+N. New hi/lo are visible from cycle t+N+1, when busy=0.
- Arithmetic:
  - MULT: signed 64-bit product, {hi,lo}.
  - MULTU: unsigned 64-bit product, {hi,lo}.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero: the busy window still runs for the full DIV_CYCLES, and hi/lo are left unchanged at commit.
- MTHI/MTLO: when valid_e and IDLE, hi (or lo) is written from v1_e at the end of that cycle, with no busy window.
- stall_req = (busy | start) & (hilo_op_d in 1..8).
  - This guarantees that no HI/LO operation reaches E while the unit is RUN, so simultaneous start or mt* during RUN cannot occur.
  - If such an E-stage op arrives anyway, it is ignored: no state change.
- hilo_e is valid in any cycle with busy=0. It is undefined-free: it always reflects the current registers.
- valid_e=0 suppresses all E-stage effects.

Decomposition:
- Shared package: HILOOp code constants (NONE..MTLO), state encoding (IDLE, RUN), and the default latency constants.
- One natural sub-module, mdu_arith: combinational 64-bit signed/unsigned multiply and divide, including the zero-divisor and overflow rules. It returns {hi,lo} plus a write-enable, which is 0 on divide-by-zero.
- The controller holds the FSM, counter, pending register, and HI/LO.

Test Plan:
1. MULT v1=3, v2=0xFFFFFFFC -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
2. MULTU v1=0xFFFFFFFF, v2=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. DIV v1=0xFFFFFFF9 (-7), v2=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. Preload hi=0x11, lo=0x22 via MTHI/MTLO (no busy). Then DIVU v2=0 -> busy 10 cycles; hi=0x11 and lo=0x22 unchanged. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Start DIV with hilo_op_d=MFLO -> stall_req=1 in the start cycle and for all 10 busy cycles, 0 in the next cycle. MFLO in E then gives hilo_e equal to the new lo. With hilo_op_d=ADD-class (0), stall_req=0 throughout.
5. Reset asserted in the 3rd busy cycle of a DIV -> next cycle busy=0, hi=0, lo=0. A new MULT 2*2 then completes normally with lo=4, hi=0.
6. valid_e=0 with hilo_op_e=MULT or MTHI -> busy stays 0 and hi/lo unchanged. Back-to-back MULT, MULT (second held by stall) -> two separate 5-cycle busy windows, with the final hi/lo from the second op.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: HILOOp codes,
// FSM state encoding, default latencies and op-class helpers.
package mdu_ctrl_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // True for ops that open a busy window.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // True for any op that touches HI/LO (codes 9..15 behave as NONE).
    function automatic logic is_hilo(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MTLO);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E/D-stage interface of the multiply/divide controller. The pipeline side
// uses the master modport, the controller uses the slave modport.
interface mdu_ctrl_if;
    logic        valid_e;
    logic [3:0]  hilo_op_e;
    logic [31:0] v1_e;
    logic [31:0] v2_e;
    logic [3:0]  hilo_op_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_e;
    logic        busy;
    logic        stall_req;

    modport master (
        output valid_e, hilo_op_e, v1_e, v2_e, hilo_op_d,
        input  hi, lo, hilo_e, busy, stall_req
    );

    modport slave (
        input  valid_e, hilo_op_e, v1_e, v2_e, hilo_op_d,
        output hi, lo, hilo_e, busy, stall_req
    );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational 64-bit multiply/divide datapath. Produces {hi,lo} and a
// write-enable that drops on divide-by-zero so HI/LO are left untouched.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        we_o
);

    logic signed [31:0] sq_s;
    logic signed [31:0] sr_s;

    // Select the arithmetic result for the requested op.
    always_comb begin
        res_o = 64'd0;
        we_o  = 1'b0;
        sq_s  = 32'sd0;
        sr_s  = 32'sd0;
        case (op_i)
            OP_MULT: begin
                res_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
                we_o  = 1'b1;
            end
            OP_MULTU: begin
                res_o = {32'd0, a_i} * {32'd0, b_i};
                we_o  = 1'b1;
            end
            OP_DIV: begin
                if (b_i == 32'd0) begin
                    we_o = 1'b0;
                end else if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
                    // The only quotient that does not fit: pin it explicitly.
                    res_o = {32'd0, 32'h8000_0000};
                    we_o  = 1'b1;
                end else begin
                    sq_s  = $signed(a_i) / $signed(b_i);
                    sr_s  = $signed(a_i) % $signed(b_i);
                    res_o = {sr_s, sq_s};
                    we_o  = 1'b1;
                end
            end
            OP_DIVU: begin
                if (b_i == 32'd0) begin
                    we_o = 1'b0;
                end else begin
                    res_o = {a_i % b_i, a_i / b_i};
                    we_o  = 1'b1;
                end
            end
            default: begin
                res_o = 64'd0;
                we_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, runs a fixed-latency busy window
// per mult/div and raises stall_req for HI/LO ops waiting in D.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_we_q, pend_we_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        start_s;
    logic        is_div_s;
    logic [63:0] arith_res_s;
    logic        arith_we_s;
    logic [31:0] hilo_e_s;

    assign start_s  = bus.valid_e & is_muldiv(bus.hilo_op_e) & (state_q == ST_IDLE);
    assign is_div_s = (bus.hilo_op_e == OP_DIV) | (bus.hilo_op_e == OP_DIVU);

    mdu_arith u_arith (
        .op_i  (bus.hilo_op_e),
        .a_i   (bus.v1_e),
        .b_i   (bus.v2_e),
        .res_o (arith_res_s),
        .we_o  (arith_we_s)
    );

    // Next-state logic for FSM, counter, pending result and HI/LO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d   = ST_RUN;
                    cnt_d     = is_div_s ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    pend_d    = arith_res_s;
                    pend_we_d = arith_we_s;
                end else if (bus.valid_e && (bus.hilo_op_e == OP_MTHI)) begin
                    hi_d = bus.v1_e;
                end else if (bus.valid_e && (bus.hilo_op_e == OP_MTLO)) begin
                    lo_d = bus.v1_e;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // E-stage HI/LO ops arriving while running are ignored.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pend_q    <= 64'd0;
            pend_we_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // mfhi/mflo read path reflects the current registers.
    always_comb begin
        case (bus.hilo_op_e)
            OP_MFHI: hilo_e_s = hi_q;
            OP_MFLO: hilo_e_s = lo_q;
            default: hilo_e_s = 32'd0;
        endcase
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.hilo_e    = hilo_e_s;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.stall_req = ((state_q == ST_RUN) | start_s) & is_hilo(bus.hilo_op_d);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural HI/LO model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state.
    logic [31:0] m_hi, m_lo, m_ph, m_pl;
    logic        m_ok;
    int          m_left;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl, output logic ok);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = m_hi; rl = m_lo; ok = 1'b1;
        if (op == OP_MULT) begin
            p = sa * sb; rh = p[63:32]; rl = p[31:0];
        end else if (op == OP_MULTU) begin
            p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0];
        end else if (b == 32'd0) begin
            ok = 1'b0;
        end else if (op == OP_DIV) begin
            q = sa / sb; r = sa % sb;
            rl = q[31:0]; rh = r[31:0];
        end else begin
            rl = a / b; rh = a % b;
        end
    endtask

    // One clock cycle: apply inputs, check every output, advance the model.
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] opd, input logic rst);
        logic st, e_busy;
        logic [31:0] e_hilo;
        @(negedge clk);
        reset = rst; bus.valid_e = v; bus.hilo_op_e = op;
        bus.v1_e = a; bus.v2_e = b; bus.hilo_op_d = opd;
        #1;
        e_busy = (m_left > 0);
        st     = v && (op >= 4'd1) && (op <= 4'd4) && !e_busy;
        e_hilo = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        check_eq("busy", bus.busy, e_busy);
        check_eq("hi", bus.hi, m_hi);
        check_eq("lo", bus.lo, m_lo);
        check_eq("hilo_e", bus.hilo_e, e_hilo);
        check_eq("stall_req", bus.stall_req, (e_busy || st) && (opd >= 4'd1) && (opd <= 4'd8));
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_ok = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_ok) begin m_hi = m_ph; m_lo = m_pl; end
        end else if (st) begin
            m_left = (op == OP_DIV || op == OP_DIVU) ? 10 : 5;
            model_op(op, a, b, m_ph, m_pl, m_ok);
        end else if (v && op == OP_MTHI) begin
            m_hi = a;
        end else if (v && op == OP_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic idle(input logic [3:0] opd);
        drive(1'b0, OP_NONE, 32'd0, 32'd0, opd, 1'b0);
    endtask

    // Counts busy cycles after a start, bounded so a stuck unit still ends.
    task automatic busy_len(input string tag, input int exp, input logic [3:0] opd);
        int n = 0;
        int stalls = 0;
        for (int i = 0; i < 40; i++) begin
            idle(opd);
            if (!bus.busy) break;
            n++;
            if (bus.stall_req) stalls++;
        end
        check_eq(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        int stalls;
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_ok = 1'b0; m_ph = 32'd0; m_pl = 32'd0;
        reset = 1'b1; bus.valid_e = 1'b0; bus.hilo_op_e = OP_NONE;
        bus.v1_e = 32'd0; bus.v2_e = 32'd0; bus.hilo_op_d = OP_NONE;
        drive(1'b0, OP_NONE, 32'd0, 32'd0, OP_NONE, 1'b1);
        drive(1'b0, OP_NONE, 32'd0, 32'd0, OP_NONE, 1'b1);
        idle(OP_NONE);
        check_eq("rst_hi", bus.hi, 32'd0);
        check_eq("rst_busy", bus.busy, 1'b0);

        // Signed and unsigned multiply, signed divide.
        drive(1'b1, OP_MULT, 32'd3, 32'hFFFF_FFFC, OP_NONE, 1'b0);
        busy_len("t1_len", 5, OP_NONE);
        check_eq("t1_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF4);
        drive(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, OP_NONE, 1'b0);
        busy_len("t2_len", 5, OP_NONE);
        check_eq("t2_multu", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, OP_NONE, 1'b0);
        busy_len("t2_dlen", 10, OP_NONE);
        check_eq("t2_div", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // mt* preload, divide by zero, overflow divide.
        drive(1'b1, OP_MTHI, 32'h11, 32'd0, OP_NONE, 1'b0);
        check_eq("t3_mt_busy", bus.busy, 1'b0);
        drive(1'b1, OP_MTLO, 32'h22, 32'd0, OP_NONE, 1'b0);
        idle(OP_NONE);
        check_eq("t3_mt", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
        drive(1'b1, OP_DIVU, 32'd1234, 32'd0, OP_NONE, 1'b0);
        busy_len("t3_dz_len", 10, OP_NONE);
        check_eq("t3_dz", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
        drive(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, OP_NONE, 1'b0);
        busy_len("t3_ovf_len", 10, OP_NONE);
        check_eq("t3_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // Stall window with MFLO waiting in D, then MFLO read.
        drive(1'b1, OP_DIV, 32'd100, 32'd7, OP_MFLO, 1'b0);
        check_eq("t4_stall_start", bus.stall_req, 1'b1);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            idle(OP_MFLO);
            if (bus.stall_req) stalls++;
        end
        check_eq("t4_stall_cnt", 64'(stalls), 64'd10);
        idle(OP_MFLO);
        check_eq("t4_stall_end", bus.stall_req, 1'b0);
        drive(1'b1, OP_MFLO, 32'd0, 32'd0, OP_NONE, 1'b0);
        check_eq("t4_mflo", bus.hilo_e, 32'd14);
        drive(1'b1, OP_DIV, 32'd100, 32'd7, OP_NONE, 1'b0);
        stalls = 0;
        for (int i = 0; i < 11; i++) begin
            idle(OP_NONE);
            if (bus.stall_req) stalls++;
        end
        check_eq("t4_nostall", 64'(stalls), 64'd0);

        // Reset in the third busy cycle of a divide.
        drive(1'b1, OP_DIV, 32'd50, 32'd3, OP_NONE, 1'b0);
        idle(OP_NONE);
        idle(OP_NONE);
        drive(1'b0, OP_NONE, 32'd0, 32'd0, OP_NONE, 1'b1);
        idle(OP_NONE);
        check_eq("t5_rst", {31'd0, bus.busy, bus.hi, bus.lo}, 96'd0);
        drive(1'b1, OP_MULT, 32'd2, 32'd2, OP_NONE, 1'b0);
        busy_len("t5_len", 5, OP_NONE);
        check_eq("t5_mult", {bus.hi, bus.lo}, 64'd4);

        // Suppressed E ops, then back-to-back multiplies.
        drive(1'b0, OP_MULT, 32'd9, 32'd9, OP_NONE, 1'b0);
        drive(1'b0, OP_MTHI, 32'h77, 32'd0, OP_NONE, 1'b0);
        idle(OP_NONE);
        check_eq("t6_inval", {31'd0, bus.busy, bus.hi, bus.lo}, 96'd4);
        drive(1'b1, OP_MULT, 32'd3, 32'd5, OP_MULT, 1'b0);
        busy_len("t6_len1", 5, OP_MULT);
        check_eq("t6_first", bus.lo, 32'd15);
        drive(1'b1, OP_MULT, 32'd7, 32'd9, OP_NONE, 1'b0);
        busy_len("t6_len2", 5, OP_NONE);
        check_eq("t6_second", {bus.hi, bus.lo}, 64'd63);

        // Random traffic, including HI/LO ops arriving while busy.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : 32'($urandom);
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 32'($urandom), b,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
